inout_sram_arbiter: RTL and testbench

- Two-requester arbiter for one single-port InOut/Weight SRAM.
- m0 is the host/DMA loader port (preload inputs/weights, drain outputs). m1 is the ConvAcc port.
- Arbitration is round-robin with an optional bounded burst lock. Read data returns to the granted requester with the SRAM's fixed 1-cycle latency.

---
 rtl/inout_sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_inout_sram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inout_sram_arbiter.sv
// Round-robin arbiter with bounded burst lock in front of one single-port SRAM.
// Port m0 is the host/DMA loader; port m1 is the conv accelerator. Reads return after a fixed 1-cycle latency.
module inout_sram_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {PORT_M0 = 1'b0, PORT_M1 = 1'b1} port_e;

  localparam int            CNT_W    = 8;
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == LOCK_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

  function automatic port_e other_port(input port_e p);
    return (p == PORT_M0) ? PORT_M1 : PORT_M0;
  endfunction

  port_e             prio;
  logic              lock_vld;
  port_e             lock_own;
  logic [CNT_W-1:0]  lock_cnt;
  logic              vld_p1;
  port_e             src_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

  logic              gnt_any;
  logic              forced;
  port_e             sel;
  logic              sel_we;
  logic              sel_lock;
  logic              other_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CNT_W-1:0]  cnt_base;

  // Stage p0: grant selection and SRAM command mux
  always_comb begin
    gnt_any = 1'b0;
    forced  = 1'b0;
    sel     = PORT_M0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        gnt_any = 1'b1;
        if (lock_vld) begin
          if (lock_cnt == LOCK_MAX) begin
            sel    = other_port(lock_own);
            forced = 1'b1;
          end else begin
            sel = lock_own;
          end
        end else begin
          sel = prio;
        end
      end else if (m0_req) begin
        gnt_any = 1'b1;
        sel     = PORT_M0;
      end else if (m1_req) begin
        gnt_any = 1'b1;
        sel     = PORT_M1;
      end
    end
  end

  assign sel_we    = (sel == PORT_M0) ? m0_we    : m1_we;
  assign sel_lock  = (sel == PORT_M0) ? m0_lock  : m1_lock;
  assign sel_addr  = (sel == PORT_M0) ? m0_addr  : m1_addr;
  assign sel_wdata = (sel == PORT_M0) ? m0_wdata : m1_wdata;
  assign other_req = (sel == PORT_M0) ? m1_req   : m0_req;
  // A lock taken over from a different owner starts counting afresh.
  assign cnt_base  = (lock_vld && (lock_own == sel)) ? lock_cnt : '0;

  assign m0_gnt    = gnt_any && (sel == PORT_M0);
  assign m1_gnt    = gnt_any && (sel == PORT_M1);
  assign mem_cs    = gnt_any;
  assign mem_we    = gnt_any & sel_we;
  assign mem_addr  = gnt_any ? sel_addr  : addr_p1;
  assign mem_wdata = gnt_any ? sel_wdata : wdata_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= PORT_M0;
      lock_vld <= 1'b0;
      lock_own <= PORT_M0;
      lock_cnt <= '0;
      vld_p1   <= 1'b0;
      src_p1   <= PORT_M0;
    end else begin
      vld_p1 <= gnt_any & ~sel_we;
      if (gnt_any) begin
        src_p1 <= sel;
        if (sel_lock && !forced) begin
          lock_vld <= 1'b1;
          lock_own <= sel;
          lock_cnt <= other_req ? sat_inc(cnt_base) : cnt_base;
        end else begin
          lock_vld <= 1'b0;
          lock_cnt <= '0;
          prio     <= other_port(sel);
        end
      end else begin
        lock_vld <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_any) begin
      addr_p1  <= sel_addr;
      wdata_p1 <= sel_wdata;
    end
  end

  // Stage p1: read return steered to the requester that issued it
  assign m0_rvalid = vld_p1 & ~rst & (src_p1 == PORT_M0);
  assign m1_rvalid = vld_p1 & ~rst & (src_p1 == PORT_M1);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_inout_sram_arbiter.sv
// Directed bench for inout_sram_arbiter: behavioural arbitration/SRAM model checked every cycle,
// plus literal expectations for each scenario.
module tb_inout_sram_arbiter;
  localparam int ADDR_W = 17, DATA_W = 32, MAX_LOCK = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_cs, mem_we;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  inout_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [DATA_W-1:0] sram    [0:1023];
  logic [DATA_W-1:0] exp_mem [0:1023];

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[9:0]];
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: preferred port, current lock owner (-1 none), length of its contested run, pending read.
  int m_turn = 0, m_owner = -1, m_streak = 0, m_pend = -1;
  logic [DATA_W-1:0] m_rd = '0, m_last_wdata = '0;
  logic [ADDR_W-1:0] m_last_addr = '0;
  bit m_last_ok = 0;

  always @(negedge clk) begin : cmp
    int g;
    bit forced, lk, oreq, we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    if (rst) begin
      chk("rst_m0_gnt", 64'(m0_gnt), 64'(0));
      chk("rst_m1_gnt", 64'(m1_gnt), 64'(0));
      chk("rst_mem_cs", 64'(mem_cs), 64'(0));
      chk("rst_m0_rvalid", 64'(m0_rvalid), 64'(0));
      chk("rst_m1_rvalid", 64'(m1_rvalid), 64'(0));
      m_turn = 0; m_owner = -1; m_streak = 0; m_pend = -1;
    end else begin
      g = -1; forced = 0;
      if (m0_req && m1_req) begin
        if (m_owner >= 0) begin
          if (m_streak >= MAX_LOCK) begin g = 1 - m_owner; forced = 1; end
          else g = m_owner;
        end else g = m_turn;
      end else if (m0_req) g = 0;
      else if (m1_req) g = 1;
      we = (g == 0) ? m0_we : (g == 1) ? m1_we : 1'b0;
      a  = (g == 1) ? m1_addr : m0_addr;
      wd = (g == 1) ? m1_wdata : m0_wdata;
      chk("m0_gnt", 64'(m0_gnt), 64'(g == 0));
      chk("m1_gnt", 64'(m1_gnt), 64'(g == 1));
      chk("mem_cs", 64'(mem_cs), 64'(g >= 0));
      chk("mem_we", 64'(mem_we), 64'(we));
      if (g >= 0) begin
        chk("mem_addr", 64'(mem_addr), 64'(a));
        if (we) chk("mem_wdata", 64'(mem_wdata), 64'(wd));
      end else if (m_last_ok) begin
        chk("mem_addr_hold", 64'(mem_addr), 64'(m_last_addr));
        chk("mem_wdata_hold", 64'(mem_wdata), 64'(m_last_wdata));
      end
      chk("m0_rvalid", 64'(m0_rvalid), 64'(m_pend == 0));
      chk("m1_rvalid", 64'(m1_rvalid), 64'(m_pend == 1));
      if (m_pend == 0) chk("m0_rdata", 64'(m0_rdata), 64'(m_rd));
      if (m_pend == 1) chk("m1_rdata", 64'(m1_rdata), 64'(m_rd));
      m_pend = -1;
      if (g >= 0) begin
        m_last_addr = a; m_last_wdata = wd; m_last_ok = 1;
        lk   = (g == 0) ? m0_lock : m1_lock;
        oreq = (g == 0) ? m1_req : m0_req;
        if (we) exp_mem[a[9:0]] = wd;
        else begin m_pend = g; m_rd = exp_mem[a[9:0]]; end
        if (lk && !forced) begin
          if (m_owner != g) m_streak = 0;
          m_owner = g;
          if (oreq && m_streak < MAX_LOCK) m_streak++;
        end else begin
          m_owner = -1; m_streak = 0; m_turn = 1 - g;
        end
      end else begin
        m_owner = -1; m_streak = 0;
      end
    end
  end

  task automatic to_neg(); @(negedge clk); endtask
  task automatic to_pos(); @(posedge clk); #1; endtask
  task automatic idle_all();
    m0_req = 0; m0_we = 0; m0_lock = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
  endtask
  task automatic do_reset();
    idle_all(); rst = 1; to_pos(); rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n0, n1, beats, cyc, gi;
    int q[$];
    for (int i = 0; i < 1024; i++) begin
      sram[i] = DATA_W'(i * 3 + 1);
      exp_mem[i] = DATA_W'(i * 3 + 1);
    end
    // Reset with both ports requesting: nothing may be granted
    m0_req = 1; m1_req = 1;
    to_pos();
    to_neg();
    chk("reset_no_grant", 64'({m0_gnt, m1_gnt, mem_cs}), 64'(0));
    to_pos();
    rst = 0; idle_all();

    // T1: m0 alone writes then reads back 0x10..0x13
    for (int k = 0; k < 4; k++) begin
      m0_req = 1; m0_we = 1; m0_addr = ADDR_W'(32'h10 + k); m0_wdata = DATA_W'(32'hA0 + k);
      to_neg(); chk("t1_wr_gnt", 64'(m0_gnt), 64'(1));
      to_pos();
    end
    for (int k = 0; k < 4; k++) begin
      m0_we = 0; m0_addr = ADDR_W'(32'h10 + k);
      to_neg();
      chk("t1_rd_gnt", 64'(m0_gnt), 64'(1));
      chk("t1_rvalid", 64'(m0_rvalid), 64'(k > 0));
      if (k > 0) chk("t1_rdata", 64'(m0_rdata), 64'(32'hA0 + k - 1));
      to_pos();
    end
    idle_all();
    to_neg();
    chk("t1_rvalid_last", 64'(m0_rvalid), 64'(1));
    chk("t1_rdata_last", 64'(m0_rdata), 64'(32'hA3));
    chk("t1_m1_rvalid", 64'(m1_rvalid), 64'(0));
    to_pos();

    // T2: both read continuously, no lock -> strict alternation from m0
    do_reset();
    m0_req = 1; m0_addr = ADDR_W'(32'h100); m1_req = 1; m1_addr = ADDR_W'(32'h200);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 20; i++) begin
      to_neg();
      if (m0_gnt) n0++;
      if (m1_gnt) n1++;
      chk("t2_alternate", 64'(m0_gnt), 64'(i % 2 == 0));
      to_pos();
    end
    chk("t2_m0_share", 64'(n0), 64'(10));
    chk("t2_m1_share", 64'(n1), 64'(10));
    idle_all();
    to_pos();

    // T3: m1 locked 40-beat burst against continuous m0 -> runs of 16 broken by one m0 grant
    do_reset();
    q.push_back(0);
    for (int i = 0; i < 16; i++) q.push_back(1);
    q.push_back(0);
    for (int i = 0; i < 16; i++) q.push_back(1);
    q.push_back(0);
    for (int i = 0; i < 8; i++) q.push_back(1);
    m0_req = 1; m0_addr = ADDR_W'(32'h100);
    m1_req = 1;
    beats = 0; cyc = 0; gi = 0;
    while (beats < 40 && cyc < 200) begin
      m1_addr = ADDR_W'(32'h200 + beats);
      m1_lock = (beats < 39);
      to_neg();
      if (m0_gnt || m1_gnt) begin
        if (gi < q.size()) chk("t3_seq", 64'(m1_gnt), 64'(q[gi]));
        gi++;
      end
      if (m1_gnt) beats++;
      to_pos();
      cyc++;
    end
    chk("t3_beats", 64'(beats), 64'(40));
    chk("t3_grants", 64'(gi), 64'(q.size()));
    idle_all();
    to_pos();

    // T4: locked m1 drops req while m0 waits
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = ADDR_W'(32'h200);
    to_neg(); chk("t4_m1_alone", 64'(m1_gnt), 64'(1)); to_pos();
    m1_addr = ADDR_W'(32'h201);
    to_neg(); to_pos();
    m0_req = 1; m0_addr = ADDR_W'(32'h100); m1_addr = ADDR_W'(32'h202);
    to_neg(); chk("t4_m0_waits", 64'(m0_gnt), 64'(0)); to_pos();
    m1_addr = ADDR_W'(32'h203);
    to_neg(); chk("t4_m0_waits2", 64'(m0_gnt), 64'(0)); to_pos();
    m1_req = 0; m1_lock = 0;
    to_neg(); chk("t4_drop_gnt", 64'(m0_gnt), 64'(1)); to_pos();
    m1_req = 1; m1_addr = ADDR_W'(32'h204);
    to_neg(); chk("t4_lock_cleared", 64'(m1_gnt), 64'(1)); to_pos();
    m1_req = 0;
    to_neg(); chk("t4_m0_after", 64'(m0_gnt), 64'(1)); to_pos();
    idle_all();
    to_pos();

    // T5: reset right after an m0 read grant swallows the read data
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = ADDR_W'(32'h20); m0_wdata = DATA_W'(32'h1234);
    to_pos();
    m0_we = 0; m0_addr = ADDR_W'(32'h10);
    to_neg(); chk("t5_rd_gnt", 64'(m0_gnt), 64'(1)); to_pos();
    rst = 1; m1_req = 1; m1_addr = ADDR_W'(32'h200);
    to_neg(); chk("t5_rvalid_in_rst", 64'(m0_rvalid), 64'(0)); to_pos();
    rst = 0;
    to_neg();
    chk("t5_rvalid_after_rst", 64'(m0_rvalid), 64'(0));
    chk("t5_prio_m0", 64'(m0_gnt), 64'(1));
    to_pos();
    idle_all();
    to_pos();

    // T6: same-cycle write (m0) and read (m1) of address 7
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = ADDR_W'(32'h7); m0_wdata = DATA_W'(32'h5555AAAA);
    m1_req = 1; m1_we = 0; m1_addr = ADDR_W'(32'h7);
    to_neg(); chk("t6_write_first", 64'({m0_gnt, m1_gnt}), 64'(2'b10)); to_pos();
    m0_req = 0; m0_we = 0;
    to_neg(); chk("t6_read_next", 64'(m1_gnt), 64'(1)); to_pos();
    m1_req = 0;
    to_neg();
    chk("t6_rvalid", 64'(m1_rvalid), 64'(1));
    chk("t6_rdata", 64'(m1_rdata), 64'(32'h5555AAAA));
    to_pos();
    to_pos();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
